// File: rtl/oh_edge2pulse_pkg.sv
// Shared definitions for the edge-to-pulse converter: edge-select encodings
// and the down-counter width helper.
package oh_edge2pulse_pkg;

    // Edge select, shared by all channels.
    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    // Width of a counter that must hold values 0..width.
    function automatic int cntw(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/oh_edge2pulse_chan.sv
// One channel of the edge-to-pulse converter: optional input synchronizer,
// previous-sample register, pulse down-counter and sticky overrun flag.
// Build option: OH_EDGE2PULSE_SYNC_EN adds a 2-flop synchronizer on in_i
// (+2 cycles of latency); when undefined, in_i must be synchronous to clk.
module oh_edge2pulse_chan
    import oh_edge2pulse_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int RETRIG = 0
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       in_i,
    input  logic [1:0] mode_i,
    input  logic       clr_i,
    output logic       out_o,
    output logic       overrun_o
);

    localparam int CW        = cntw(WIDTH);
    localparam bit RETRIG_EN = (RETRIG != 0);

    logic          in_s;
    logic          in_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q;
    logic          overrun_q, overrun_d;
    logic          rise, fall, det;

`ifdef OH_EDGE2PULSE_SYNC_EN
    logic [1:0] sync_q;

    // Two-stage synchronizer; resets to 0 so a high input still yields a rise.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) sync_q <= 2'b00;
        else         sync_q <= {sync_q[0], in_i};
    end

    assign in_s = sync_q[1];
`else
    assign in_s = in_i;
`endif

    // Edge detection against the previous sample, filtered by the edge select.
    always_comb begin
        rise = in_s & ~in_q;
        fall = ~in_s & in_q;
        // NOTE: every always_comb output gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        det  = 1'b0;
        unique case (edge_mode_e'(mode_i))
            EDGE_OFF:  det = 1'b0;
            EDGE_RISE: det = rise;
            EDGE_FALL: det = fall;
            EDGE_BOTH: det = rise | fall;
            default:   det = 1'b0;
        endcase
    end

    // Counter reload/decrement and sticky overrun next state.
    always_comb begin
        cnt_d = cnt_q;
        if (det && (RETRIG_EN || cnt_q <= CW'(1))) cnt_d = CW'(WIDTH);
        else if (cnt_q != '0)                     cnt_d = cnt_q - CW'(1);

        // Set beats clear when both happen in the same cycle.
        overrun_d = overrun_q;
        if (clr_i)                                    overrun_d = 1'b0;
        if (det && !RETRIG_EN && (cnt_q > CW'(1)))    overrun_d = 1'b1;
        if (RETRIG_EN)                                overrun_d = 1'b0;
    end

    // State registers; out is registered so no combinational path reaches it.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            in_q      <= 1'b0;
            cnt_q     <= '0;
            out_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge values, independent of statement order.
            in_q      <= in_s;
            cnt_q     <= cnt_d;
            out_q     <= (cnt_d != '0);
            overrun_q <= overrun_d;
        end
    end

    assign out_o     = out_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/oh_edge2pulse.sv
// Per-channel edge detector producing WIDTH-cycle registered pulses, with
// selectable edge type, optional retrigger and sticky overrun flags.
// Build option: OH_EDGE2PULSE_SYNC_EN enables per-channel input synchronizers.
module oh_edge2pulse
    import oh_edge2pulse_pkg::*;
#(
    parameter int N      = 1,
    parameter int WIDTH  = 1,
    parameter int RETRIG = 0
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic [N-1:0] in,
    input  logic [1:0]   mode,
    input  logic [N-1:0] clr,
    output logic [N-1:0] out,
    output logic [N-1:0] overrun
);

    for (genvar g = 0; g < N; g++) begin : g_chan
        oh_edge2pulse_chan #(
            .WIDTH  (WIDTH),
            .RETRIG (RETRIG)
        ) u_chan (
            .clk       (clk),
            .nreset    (nreset),
            .in_i      (in[g]),
            .mode_i    (mode),
            .clr_i     (clr[g]),
            .out_o     (out[g]),
            .overrun_o (overrun[g])
        );
    end

endmodule
